// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Purpose  : DEPTH x WIDTH general-purpose register storage. Byte-lane masked
//            write port and a registered, strobed read port with write-first
//            bypass, a one-cycle Valid pulse and an address-error pulse.
// Revision : 1.0  initial multi-entry release
// ============================================================================
module register_bank #(
  parameter int WIDTH  = 64,  // word width, multiple of 8
  parameter int DEPTH  = 8,   // number of entries, 1 .. 2**ADDR_W
  parameter int ADDR_W = 3    // address width
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 En,
  input  logic [ADDR_W-1:0]    WrAddr,
  input  logic [WIDTH/8-1:0]   ByteEn,
  input  logic [WIDTH-1:0]     in,
  input  logic                 Read,
  input  logic [ADDR_W-1:0]    RdAddr,
  output logic [WIDTH-1:0]     out,
  output logic                 Valid,
  output logic                 Err
);

  localparam int NUM_BYTES = WIDTH / 8;

  // --------------------------------------------------------------------------
  // Storage and output registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             valid_q;
  logic             valid_d;
  logic             err_q;
  logic             err_d;

  // --------------------------------------------------------------------------
  // Address qualification. DEPTH need not be a power of two, so addresses at
  // or above DEPTH are legal encodings that must be rejected.
  // --------------------------------------------------------------------------
  logic wr_in_range;
  logic rd_in_range;
  logic wr_ok;
  logic rd_ok;
  logic wr_bad;
  logic rd_bad;
  logic bypass;

  assign wr_in_range = (32'(WrAddr) < 32'(DEPTH));
  assign rd_in_range = (32'(RdAddr) < 32'(DEPTH));
  assign wr_ok       = En   &&  wr_in_range;
  assign rd_ok       = Read &&  rd_in_range;
  assign wr_bad      = En   && !wr_in_range;
  assign rd_bad      = Read && !rd_in_range;
  // Same-edge write and read of one good entry: read sees the written bytes.
  assign bypass      = wr_ok && rd_ok && (WrAddr == RdAddr);

  // --------------------------------------------------------------------------
  // Read-side word selection. The mux only covers real entries, so an
  // out-of-range address never indexes past the array.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] merged_word;

  // Select the currently stored word at RdAddr
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddr == ADDR_W'(i)) begin
        rd_word = mem_q[i];
      end
    end
  end

  // Per byte lane: enabled lanes take write data, others keep the stored byte.
  // This is exactly the value the entry holds after the write completes.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    assign merged_word[8*k +: 8] = ByteEn[k] ? in[8*k +: 8] : rd_word[8*k +: 8];
  end

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------

  // Next entry contents: byte-masked update of the addressed entry only
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_ok && (WrAddr == ADDR_W'(i))) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (ByteEn[k]) begin
            mem_d[i][8*k +: 8] = in[8*k +: 8];
          end
        end
      end
    end
  end

  // Entry registers, cleared asynchronously
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path and status
  // --------------------------------------------------------------------------

  // Next read data and status pulses; out holds when no read is strobed
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = wr_bad || rd_bad;
    if (Read) begin
      if (rd_ok) begin
        out_d   = bypass ? merged_word : rd_word;
        valid_d = 1'b1;
      end else begin
        out_d   = '0;
      end
    end
  end

  // Output registers, cleared asynchronously
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out   = out_q;
  assign Valid = valid_q;
  assign Err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_bank
// Purpose  : Self-checking bench for register_bank (WIDTH=64, DEPTH=6,
//            ADDR_W=3) with directed scenarios and a randomized phase checked
//            against an array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_register_bank;

  localparam int W  = 64;
  localparam int D  = 6;
  localparam int AW = 3;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          En = 1'b0;
  logic [AW-1:0] WrAddr = '0;
  logic [W/8-1:0] ByteEn = '0;
  logic [W-1:0]  in = '0;
  logic          Read = 1'b0;
  logic [AW-1:0] RdAddr = '0;
  logic [W-1:0]  out;
  logic          Valid;
  logic          Err;

  register_bank #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .WrAddr(WrAddr), .ByteEn(ByteEn),
    .in(in), .Read(Read), .RdAddr(RdAddr), .out(out), .Valid(Valid), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_out   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict from the model, check after the edge
  task automatic cycle(input logic en, input logic [AW-1:0] wa, input logic [W/8-1:0] be,
                       input logic [W-1:0] d, input logic rd, input logic [AW-1:0] ra);
    logic [W-1:0] nm [D];
    logic [W-1:0] e_out;
    logic         e_valid;
    logic         e_err;
    En = en; WrAddr = wa; ByteEn = be; in = d; Read = rd; RdAddr = ra;
    nm = m_mem;
    if (en && int'(wa) < D)
      for (int k = 0; k < W/8; k++)
        if (be[k]) nm[wa][8*k +: 8] = d[8*k +: 8];
    e_err = (en && int'(wa) >= D) || (rd && int'(ra) >= D);
    if (rd) begin
      if (int'(ra) < D) begin e_out = nm[ra]; e_valid = 1'b1; end
      else              begin e_out = '0;     e_valid = 1'b0; end
    end else begin
      e_out = m_out; e_valid = 1'b0;
    end
    @(posedge Clk); #1;
    chk("out", out, e_out);
    chk("valid", W'(Valid), W'(e_valid));
    chk("err", W'(Err), W'(e_err));
    m_mem = nm; m_out = e_out; m_valid = e_valid; m_err = e_err;
    En = 1'b0; Read = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Reset pulse between clock edges; outputs must clear without an edge
  task automatic mid_reset(input string tag);
    Rst = 1'b1;
    #2;
    chk({tag, "_out"},   out,       '0);
    chk({tag, "_valid"}, W'(Valid), '0);
    chk({tag, "_err"},   W'(Err),   '0);
    #1;
    Rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    // Power-on reset
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("por_out", out, '0);
    chk("por_valid", W'(Valid), '0);
    chk("por_err", W'(Err), '0);

    // Put data in, leave Valid high, then reset with no clock edge
    cycle(1'b1, 3'd0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, '0, 1'b1, 3'd0);
    chk("pre_reset_valid", W'(Valid), 64'd1);
    mid_reset("async_rst");

    // Every address reads zero; 6 and 7 are out of range
    for (int a = 0; a < 8; a++) cycle(1'b0, '0, '0, '0, 1'b1, AW'(a));

    // Full write then read, then hold for three cycles
    cycle(1'b1, 3'd3, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, '0, 1'b1, 3'd3);
    chk("full_rd", out, 64'h0123456789ABCDEF);
    chk("full_valid", W'(Valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("hold_out", out, 64'h0123456789ABCDEF);
      chk("hold_valid", W'(Valid), 64'd0);
    end

    // Byte mask: low four lanes only
    cycle(1'b1, 3'd3, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 8'h00, '0, 1'b1, 3'd3);
    chk("mask_rd", out, 64'h01234567FFFFFFFF);

    // Bypass on the same entry
    cycle(1'b1, 3'd5, 8'h03, 64'h000000000000A5A5, 1'b1, 3'd5);
    chk("bypass_rd", out, 64'h000000000000A5A5);
    // Different entries: read returns old contents of addr 2
    cycle(1'b1, 3'd2, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, 3'd0);
    cycle(1'b1, 3'd2, 8'hFF, 64'h9999_8888_7777_6666, 1'b1, 3'd2);
    chk("same_addr_new", out, 64'h9999_8888_7777_6666);
    cycle(1'b1, 3'd5, 8'hFF, 64'h5555_5555_5555_5555, 1'b1, 3'd2);
    chk("diff_addr_old", out, 64'h9999_8888_7777_6666);

    // Out-of-range write: Err pulse, nothing changes
    cycle(1'b1, 3'd7, 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 3'd0);
    chk("oor_wr_err", W'(Err), 64'd1);
    idle();
    chk("oor_wr_err_clear", W'(Err), 64'd0);
    for (int a = 0; a < D; a++) cycle(1'b0, '0, '0, '0, 1'b1, AW'(a));

    // Out-of-range read: out cleared, no Valid, one Err pulse
    cycle(1'b0, 3'd0, 8'h00, '0, 1'b1, 3'd6);
    chk("oor_rd_out", out, 64'd0);
    chk("oor_rd_valid", W'(Valid), 64'd0);
    chk("oor_rd_err", W'(Err), 64'd1);
    idle();
    chk("oor_rd_err_clear", W'(Err), 64'd0);

    // Both bad together, then good write with bad read, bad write with good read
    cycle(1'b1, 3'd6, 8'hFF, '1, 1'b1, 3'd7);
    idle();
    cycle(1'b1, 3'd4, 8'hF0, 64'hABCD_EF01_2345_6789, 1'b1, 3'd6);
    cycle(1'b1, 3'd7, 8'hFF, '1, 1'b1, 3'd4);
    chk("mixed_good_rd", out, 64'hABCD_EF01_0000_0000);

    // Reset between a write and the following read
    cycle(1'b1, 3'd1, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 3'd0);
    mid_reset("op_rst");
    cycle(1'b0, 3'd0, 8'h00, '0, 1'b1, 3'd1);
    chk("post_rst_rd", out, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)),
            8'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
